// File: rtl/pcie_sym_pkg.sv
// Purpose: shared 8b symbol constants and framing FSM encoding for byte_strip / byte_unstrip.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pcie_sym_pkg;

  // Framing symbols: carried with DK=0.
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;

  // Ordered-set / filler symbols: treated like data, carried with DK=1.
  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } fsm_state_t;

  // Packet-opening framing symbol.
  function automatic logic is_start(input logic [7:0] s);
    return (s == SYM_STP) || (s == SYM_SDP);
  endfunction

  // Packet-closing framing symbol.
  function automatic logic is_end(input logic [7:0] s);
    return (s == SYM_END) || (s == SYM_EDB);
  endfunction

endpackage

// File: rtl/unstrip_checker.sv
// Purpose: framing position / DK class checker, computes next framing state for one symbol.
// Latency: purely combinational; caller registers the results alongside the symbol.
// Backpressure: none; evaluated only when the caller qualifies the symbol as emitted.
module unstrip_checker
  import pcie_sym_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] sym,
  input  logic            dk,
  input  logic [1:0]      idx,
  input  fsm_state_t      state,
  output fsm_state_t      next_state,
  output logic            err_pos,
  output logic            err_dk
);

  logic [7:0] sym8;
  logic       start_sym;
  logic       end_sym;

  assign sym8      = 8'(sym);
  assign start_sym = is_start(sym8);
  assign end_sym   = is_end(sym8);

  // Framing rules: starts only at lane 0, ends only at lane 3. A misplaced
  // symbol leaves the state alone; a start inside a packet restarts it (stays
  // PKT) and an end outside a packet stays IDLE, both flagged.
  always_comb begin
    next_state = state;
    err_pos    = 1'b0;
    if (start_sym) begin
      err_pos = (idx != 2'd0) || (state == ST_PKT);
      if (idx == 2'd0) next_state = ST_PKT;
    end else if (end_sym) begin
      err_pos = (idx != 2'd3) || (state == ST_IDLE);
      if (idx == 2'd3) next_state = ST_IDLE;
    end
  end

  // Framing symbols must be DK=0, everything else DK=1; never gates transitions.
  assign err_dk = (start_sym || end_sym) ? dk : ~dk;

endmodule

// File: rtl/byte_unstrip.sv
// Purpose: merge a 4-lane symbol group back into one serial symbol stream with framing/DK checks.
// Latency: group accepted at edge N (serializer idle) -> lane 0 on D after N+1, lane 3 after N+4.
// Backpressure: IN_READY (registered) high only while the one-group holding register is empty.
module byte_unstrip
  import pcie_sym_pkg::*;
#(
  parameter int LANES = 4,  // only 4 is supported
  parameter int BITS  = 8
) (
  input  logic            CLK,
  input  logic            RESET_L,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [BITS-1:0] LANE0,
  input  logic [BITS-1:0] LANE1,
  input  logic [BITS-1:0] LANE2,
  input  logic [BITS-1:0] LANE3,
  input  logic [3:0]      LANE_DK,
  output logic [BITS-1:0] D,
  output logic            o_DK,
  output logic            OUT_VALID,
  output logic            IN_PKT,
  output logic            ERR_POS,
  output logic            ERR_DK
);

  localparam logic [1:0] LAST_IDX = 2'(LANES - 1);

  logic [LANES-1:0][BITS-1:0] in_dat;

  // One-group skid/holding register.
  logic                       hold_vld;
  logic [LANES-1:0][BITS-1:0] hold_dat;
  logic [LANES-1:0]           hold_dk;

  // Group currently being serialized; idx is the lane emitted next.
  logic                       ser_vld;
  logic [LANES-1:0][BITS-1:0] ser_dat;
  logic [LANES-1:0]           ser_dk;
  logic [1:0]                 idx;

  logic                       accept;
  logic                       take_hold;
  logic                       hold_vld_nxt;
  logic                       emit_vld;
  logic [BITS-1:0]            emit_sym;
  logic                       emit_dk;

  fsm_state_t                 state_q;
  fsm_state_t                 state_nxt;
  fsm_state_t                 chk_state;
  logic                       chk_err_pos;
  logic                       chk_err_dk;

  assign in_dat = {LANE3, LANE2, LANE1, LANE0};
  assign accept = IN_VALID && IN_READY;

  // The holding group moves on when the serializer is idle (its lane 0 goes
  // straight out) or when lane 3 of the current group leaves.
  assign take_hold    = hold_vld && (!ser_vld || (idx == LAST_IDX));
  assign hold_vld_nxt = accept || (hold_vld && !take_hold);

  // Select the symbol leaving this cycle; idx is 0 whenever the serializer is empty.
  always_comb begin
    emit_vld = 1'b0;
    emit_sym = '0;
    emit_dk  = 1'b0;
    if (ser_vld) begin
      emit_vld = 1'b1;
      emit_sym = ser_dat[idx];
      emit_dk  = ser_dk[idx];
    end else if (hold_vld) begin
      emit_vld = 1'b1;
      emit_sym = hold_dat[0];
      emit_dk  = hold_dk[0];
    end
  end

  unstrip_checker #(
    .BITS(BITS)
  ) u_chk (
    .sym       (emit_sym),
    .dk        (emit_dk),
    .idx       (idx),
    .state     (state_q),
    .next_state(chk_state),
    .err_pos   (chk_err_pos),
    .err_dk    (chk_err_dk)
  );

  // Framing state advances only on emitted symbols.
  always_comb begin
    state_nxt = state_q;
    if (emit_vld) state_nxt = chk_state;
  end

  // Framing state register.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  // Holding register, serializer and lane index.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
      hold_dk  <= '0;
      ser_vld  <= 1'b0;
      ser_dat  <= '0;
      ser_dk   <= '0;
      idx      <= 2'd0;
      IN_READY <= 1'b0;
    end else begin
      if (accept) begin
        hold_dat <= in_dat;
        hold_dk  <= LANE_DK;
      end
      hold_vld <= hold_vld_nxt;
      IN_READY <= !hold_vld_nxt;
      if (take_hold) begin
        ser_dat <= hold_dat;
        ser_dk  <= hold_dk;
        ser_vld <= 1'b1;
      end else if (ser_vld && (idx == LAST_IDX)) begin
        ser_vld <= 1'b0;
      end
      if (emit_vld) idx <= idx + 2'd1;
    end
  end

  // Output stage: symbol, its DK and the check results stay aligned; D/o_DK hold when idle.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      D         <= '0;
      o_DK      <= 1'b0;
      OUT_VALID <= 1'b0;
      IN_PKT    <= 1'b0;
      ERR_POS   <= 1'b0;
      ERR_DK    <= 1'b0;
    end else begin
      if (emit_vld) begin
        D    <= emit_sym;
        o_DK <= emit_dk;
      end
      OUT_VALID <= emit_vld;
      IN_PKT    <= (state_nxt == ST_PKT);
      ERR_POS   <= emit_vld && chk_err_pos;
      ERR_DK    <= emit_vld && chk_err_dk;
    end
  end

endmodule

// File: tb/tb_byte_unstrip.sv
// Purpose: self-checking bench for byte_unstrip (group table + scoreboard, reset corners).
// Latency: checks lane 0 one edge after accept and contiguous back-to-back output.
// Backpressure: driver holds IN_VALID and data until IN_READY is seen high.
module tb_byte_unstrip;

  typedef struct {
    logic [7:0] l0, l1, l2, l3;
    logic [3:0] dk;
    logic [3:0] pkt;   // expected IN_PKT per lane
    logic [3:0] epos;  // expected ERR_POS per lane
    logic [3:0] edk;   // expected ERR_DK per lane
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       dk, pkt, epos, edk;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] LANE0, LANE1, LANE2, LANE3;
  logic [3:0] LANE_DK;
  logic [7:0] D;
  logic       o_DK, OUT_VALID, IN_PKT, ERR_POS, ERR_DK;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   acc_cyc;
  exp_t exp_q[$];
  int   vld_cyc_q[$];
  vec_t tbl[12];
  vec_t mid_v, post_v;

  byte_unstrip #(.LANES(4), .BITS(8)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .LANE0(LANE0), .LANE1(LANE1), .LANE2(LANE2), .LANE3(LANE3), .LANE_DK(LANE_DK),
    .D(D), .o_DK(o_DK), .OUT_VALID(OUT_VALID), .IN_PKT(IN_PKT),
    .ERR_POS(ERR_POS), .ERR_DK(ERR_DK)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_D"}, 32'(D), 0);
    chk({tag, "_DK"}, 32'(o_DK), 0);
    chk({tag, "_OUT_VALID"}, 32'(OUT_VALID), 0);
    chk({tag, "_IN_READY"}, 32'(IN_READY), 0);
    chk({tag, "_IN_PKT"}, 32'(IN_PKT), 0);
    chk({tag, "_ERR_POS"}, 32'(ERR_POS), 0);
    chk({tag, "_ERR_DK"}, 32'(ERR_DK), 0);
  endtask

  // Drive one group, wait for acceptance, then queue its four expected symbols.
  task automatic send(input vec_t v, input bit keep_valid);
    int   b;
    exp_t e;
    logic [7:0] s [4];
    IN_VALID = 1'b1;
    LANE0 = v.l0; LANE1 = v.l1; LANE2 = v.l2; LANE3 = v.l3;
    LANE_DK = v.dk;
    b = 0;
    do begin
      @(negedge CLK);
      b++;
    end while (!IN_READY && b < 50);
    if (!IN_READY) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: IN_READY=0 after %0d cycles, required 1", b);
      IN_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    s[0] = v.l0; s[1] = v.l1; s[2] = v.l2; s[3] = v.l3;
    for (int i = 0; i < 4; i++) begin
      e.d    = s[i];
      e.dk   = v.dk[i];
      e.pkt  = v.pkt[i];
      e.epos = v.epos[i];
      e.edk  = v.edk[i];
      exp_q.push_back(e);
    end
    #1;
    acc_cyc = cyc;
    if (!keep_valid) IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(negedge CLK);
      #1;
      b++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d symbols outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: every valid output is compared against the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET_L === 1'b1 && OUT_VALID === 1'b1) begin
      vld_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: D=%0h OUT_VALID=1, required no output", D);
      end else begin
        e = exp_q.pop_front();
        chk("sym_D", 32'(D), 32'(e.d));
        chk("sym_DK", 32'(o_DK), 32'(e.dk));
        chk("sym_IN_PKT", 32'(IN_PKT), 32'(e.pkt));
        chk("sym_ERR_POS", 32'(ERR_POS), 32'(e.epos));
        chk("sym_ERR_DK", 32'(ERR_DK), 32'(e.edk));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    //            l0     l1     l2     l3     dk       pkt      epos     edk
    tbl[0]  = '{8'hFB, 8'h01, 8'h02, 8'h03, 4'b1110, 4'b1111, 4'b0000, 4'b0000};
    tbl[1]  = '{8'h44, 8'h55, 8'h66, 8'hFD, 4'b0111, 4'b0111, 4'b0000, 4'b0000};
    tbl[2]  = '{8'hFB, 8'h11, 8'h22, 8'h33, 4'b1110, 4'b1111, 4'b0000, 4'b0000};
    tbl[3]  = '{8'h44, 8'h55, 8'h66, 8'hFD, 4'b0111, 4'b0111, 4'b0000, 4'b0000};
    tbl[4]  = '{8'h10, 8'hFD, 8'h20, 8'h30, 4'b1101, 4'b0000, 4'b0010, 4'b0000};
    tbl[5]  = '{8'h5C, 8'h7C, 8'h7C, 8'h7C, 4'b1111, 4'b1111, 4'b0000, 4'b0001};
    tbl[6]  = '{8'hFB, 8'hAA, 8'hBB, 8'hCC, 4'b1110, 4'b1111, 4'b0001, 4'b0000};
    tbl[7]  = '{8'h01, 8'h02, 8'hFE, 8'h03, 4'b1011, 4'b1111, 4'b0100, 4'b0000};
    tbl[8]  = '{8'h1C, 8'h7C, 8'hBC, 8'hFE, 4'b0111, 4'b0111, 4'b0000, 4'b0000};
    tbl[9]  = '{8'h00, 8'h00, 8'h00, 8'hFD, 4'b0111, 4'b0000, 4'b1000, 4'b0000};
    tbl[10] = '{8'h77, 8'hFB, 8'h88, 8'h99, 4'b1111, 4'b0000, 4'b0010, 4'b0010};
    tbl[11] = '{8'h5C, 8'h01, 8'h02, 8'h03, 4'b1110, 4'b1111, 4'b0000, 4'b0000};
    mid_v   = '{8'h5C, 8'hA1, 8'hA2, 8'hA3, 4'b1110, 4'b1111, 4'b0001, 4'b0000};
    post_v  = '{8'h00, 8'h00, 8'h00, 8'hFD, 4'b0111, 4'b0000, 4'b1000, 4'b0000};

    RESET_L = 1'b0;
    IN_VALID = 1'b0;
    LANE0 = '0; LANE1 = '0; LANE2 = '0; LANE3 = '0; LANE_DK = '0;

    // Reset values and IN_READY rising on the first edge after release.
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    @(negedge CLK);
    RESET_L = 1'b1;
    #1;
    chk("ready_before_edge", 32'(IN_READY), 0);
    @(posedge CLK);
    #1;
    chk("ready_after_release", 32'(IN_READY), 1);

    // Single group into an idle serializer: lane 0 at N+1, lane 3 at N+4.
    vld_cyc_q.delete();
    send(tbl[0], 1'b0);
    drain();
    chk("latency_lane0", 32'(vld_cyc_q.size() > 0 ? vld_cyc_q[0] - acc_cyc : -1), 1);
    chk("latency_lane3", 32'(vld_cyc_q.size() > 3 ? vld_cyc_q[3] - acc_cyc : -1), 4);

    // Back-to-back groups with IN_VALID held high (sender stalls on IN_READY=0).
    repeat (3) @(posedge CLK);
    #1;
    vld_cyc_q.delete();
    for (int i = 1; i < 12; i++) send(tbl[i], 1'b1);
    IN_VALID = 1'b0;
    drain();
    chk("b2b_count", 32'(vld_cyc_q.size()), 44);
    chk("b2b_span", 32'(vld_cyc_q.size() > 0 ? vld_cyc_q[$] - vld_cyc_q[0] + 1 : 0), 44);

    // Idle output holds the last symbol with OUT_VALID low.
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_OUT_VALID", 32'(OUT_VALID), 0);
    chk("idle_D_hold", 32'(D), 32'h03);
    chk("idle_DK_hold", 32'(o_DK), 1);

    // Reset asserted while the second symbol of a group is on D.
    send(mid_v, 1'b0);
    begin
      int b;
      b = 0;
      while (exp_q.size() > 2 && b < 50) begin
        @(negedge CLK);
        #1;
        b++;
      end
      chk("mid_two_symbols_out", 32'(exp_q.size()), 2);
    end
    RESET_L = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_L = 1'b1;
    #1;
    chk("mid_ready_before_edge", 32'(IN_READY), 0);
    @(posedge CLK);
    #1;
    chk("mid_ready_after_release", 32'(IN_READY), 1);
    // No stale symbols may appear; the scoreboard flags any output now.
    repeat (8) @(posedge CLK);
    #1;
    chk("mid_no_stale", 32'(OUT_VALID), 0);

    // FSM restarted in IDLE: an END at lane 3 is now out of place.
    send(post_v, 1'b0);
    drain();
    repeat (3) @(posedge CLK);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_unstrip.md
BYTE_UNSTRIP -- requirements
Module: byte_unstrip

Interface
REQ-001 SHALL have parameter LANES, default 4, the number of lanes merged; only 4 is supported.
REQ-002 SHALL have parameter BITS, default 8, the symbol width in bits.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET_L, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 SHALL have port IN_VALID, input, 1 bit: a lane group is present on LANE0..LANE3.
REQ-006 SHALL have port IN_READY, output, 1 bit, registered: the block can accept a group.
REQ-007 SHALL have ports LANE0, LANE1, LANE2, LANE3, input, BITS bits each: lane symbols 0..3.
REQ-008 SHALL have port LANE_DK, input, 4 bits: per-lane DK flag, where bit i belongs to LANEi.
REQ-009 SHALL have port D, output, BITS bits, registered: the serialized symbol.
REQ-010 SHALL have port o_DK, output, 1 bit, registered: the DK flag of D.
REQ-011 SHALL have port OUT_VALID, output, 1 bit, registered: D and o_DK are valid.
REQ-012 SHALL have port IN_PKT, output, 1 bit, registered: the framing FSM is in PKT.
REQ-013 SHALL have port ERR_POS, output, 1 bit, registered: a one-cycle pulse flagging a framing symbol in the wrong position.
REQ-014 SHALL have port ERR_DK, output, 1 bit, registered: a one-cycle pulse flagging a wrong DK for the symbol class.

Function
REQ-015 SHALL accept a group on the rising edge where IN_VALID=1 and IN_READY=1, capturing all four lanes and LANE_DK into a holding register.
REQ-016 SHALL drive IN_READY=1 exactly when the holding register is empty.
REQ-017 SHALL ignore IN_VALID while IN_READY=0; the group is neither captured nor dropped silently (the sender holds it).
REQ-018 SHALL move the holding register into the serializer when the serializer is empty, or on the edge that emits lane index 3, freeing the holding register in that same edge.
REQ-019 SHALL emit one symbol per cycle in lane order 0,1,2,3, with OUT_VALID=1; a 2-bit index tracks the lane and wraps from 3 to 0.
REQ-020 SHALL have latency: group accepted at edge N with the serializer idle gives LANE0 on D after edge N+1 and LANE3 after edge N+4.
REQ-021 SHALL sustain back-to-back groups with no OUT_VALID gap when IN_VALID is held high.
REQ-022 SHALL hold OUT_VALID=0 and hold the previous D and o_DK values when no symbol is available.
REQ-023 SHALL forward symbols and DK unmodified; checks never alter the data.
REQ-024 SHALL classify symbols as follows: framing = STP 8'hFB, SDP 8'h5C, END 8'hFD, EDB 8'hFE, which require DK=0; all others (including SKP 8'h1C, IDL 8'h7C, COM 8'hBC) require DK=1.
REQ-025 SHALL implement an FSM with states IDLE and PKT, evaluated on each emitted symbol.
REQ-026 SHALL transition IDLE->PKT on STP or SDP at index 0.
REQ-027 SHALL transition PKT->IDLE on END or EDB at index 3.
REQ-028 SHALL pulse ERR_POS when STP or SDP appears at an index other than 0, or END or EDB at an index other than 3; the state is unchanged.
REQ-029 SHALL pulse ERR_POS when STP or SDP arrives at index 0 while in PKT; the state stays PKT (packet restart).
REQ-030 SHALL pulse ERR_POS when END or EDB arrives at index 3 while in IDLE; the state stays IDLE.
REQ-031 SHALL pulse ERR_DK on a DK/class mismatch; the mismatch does not block FSM transitions.
REQ-032 SHALL align the error pulses and IN_PKT with the cycle in which the offending symbol is on D.

Reset
REQ-033 SHALL, while RESET_L=0, asynchronously force: D=0, o_DK=0, OUT_VALID=0, IN_READY=0, IN_PKT=0, ERR_POS=0, ERR_DK=0, FSM=IDLE, index=0, buffers empty.
REQ-034 SHALL drive IN_READY=1 on the first edge after RESET_L deasserts.
REQ-035 SHALL discard buffered symbols on reset asserted mid-group, with no partial group emitted afterward.

Structure
REQ-036 SHALL place the symbol constants (STP, SDP, END, EDB, COM, SKP, IDL) and the FSM state encoding in the shared package pcie_sym_pkg, which is also used by byte_strip.
REQ-037 SHALL place the framing and DK checker in one sub-module, unstrip_checker, which takes a symbol, DK and index and returns the next state and the error flags.

Verification
REQ-038 SHALL cover this scenario: group FB/01/02/03 with LANE_DK=4'b1110 -> D = FB,01,02,03 at cycles N+1..N+4, IN_PKT=1 from N+1, no errors.
REQ-039 SHALL cover this scenario: groups FB/11/22/33 then 44/55/66/FD (DK 1110, then 0111) sent back-to-back -> 8 contiguous OUT_VALID cycles, IN_PKT falls after FD.
REQ-040 SHALL cover this scenario: group 10/FD/20/30 with DK 1101 -> ERR_POS pulses with FD on D, IN_PKT unchanged.
REQ-041 SHALL cover this scenario: group 5C/7C/7C/7C with LANE_DK=4'b1111 -> ERR_DK pulses on 5C, IN_PKT=1.
REQ-042 SHALL cover this scenario: IN_VALID held high with IN_READY low -> the stalled group is emitted exactly once, in order.
REQ-043 SHALL cover this scenario: RESET_L low after the second symbol of a group -> all outputs 0 immediately, IN_READY=1 one edge after release, no stale symbols.
